// File: rtl/sram2rw_ctrl_pkg.sv
// sram2rw_ctrl_pkg: shared widths, macro command/tag types and command update helper
package sram2rw_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 39;
  localparam int N_REQ_MAX = 8;
  localparam int IDW = $clog2(N_REQ_MAX);
  typedef struct packed {
    logic csb;
    logic web;
    logic oeb;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] i;
  } sram_cmd_t;
  localparam sram_cmd_t SRAM_CMD_IDLE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, a: '0, i: '0};
  typedef struct packed {
    logic vld;
    logic [IDW-1:0] id;
  } rd_tag_t;
  // address and write data hold when idle so the macro pins do not toggle
  function automatic sram_cmd_t next_cmd(sram_cmd_t cur, logic gnt, logic we,
                                         logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    next_cmd = cur;
    next_cmd.csb = ~gnt;
    next_cmd.web = ~(gnt & we);
    next_cmd.oeb = ~(gnt & ~we);
    if (gnt) next_cmd.a = a;
    if (gnt && we) next_cmd.i = d;
  endfunction
endpackage

// File: rtl/sram2rw_port_arbiter_if.sv
// sram2rw_port_arbiter_if: requester request/response bus for the port arbiter
interface sram2rw_port_arbiter_if #(parameter int N_REQ = 4);
  import sram2rw_ctrl_pkg::*;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0] resp_valid;
  logic [N_REQ*DATA_W-1:0] resp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input req_ready, resp_valid, resp_rdata);
  modport slave (input req_valid, req_we, req_addr, req_wdata,
                 output req_ready, resp_valid, resp_rdata);
endinterface

// File: rtl/sram2rw_rr_pick.sv
// sram2rw_rr_pick: round-robin find-first over unmasked requests starting at ptr
module sram2rw_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 vld,
  output logic [$clog2(N)-1:0] idx
);
  localparam int PW = $clog2(N);
  logic [N-1:0] cand, rot;
  int first;
  assign cand = req & ~mask;
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) rot[j] = cand[(int'(ptr) + j) % N];
    first = 0;
    for (int j = N - 1; j >= 0; j--) first = rot[j] ? j : first;
    vld = |rot;
    idx = PW'((int'(ptr) + first) % N);
    gnt = vld ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sram2rw_port_arbiter.sv
// sram2rw_port_arbiter: shares a dual-port SRAM2RW32x39 macro among N_REQ requesters
module sram2rw_port_arbiter
  import sram2rw_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  sram2rw_port_arbiter_if.slave bus,
  output logic              sram_csb1,
  output logic              sram_web1,
  output logic              sram_oeb1,
  output logic [ADDR_W-1:0] sram_a1,
  output logic [DATA_W-1:0] sram_i1,
  input  logic [DATA_W-1:0] sram_o1,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic              sram_oeb2,
  output logic [ADDR_W-1:0] sram_a2,
  output logic [DATA_W-1:0] sram_i2,
  input  logic [DATA_W-1:0] sram_o2
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] rr_ptr, idx1, idx2, last;
  logic [N_REQ-1:0] gnt1, gnt2, conflict;
  logic v1, v2, we1, we2;
  logic [ADDR_W-1:0] a1;
  sram_cmd_t cmd1, cmd2;
  rd_tag_t t1_p1, t1_p2, t2_p1, t2_p2;
  assign a1 = bus.req_addr[idx1*ADDR_W +: ADDR_W];
  assign we1 = bus.req_we[idx1];
  assign we2 = bus.req_we[idx2];
  // two reads of one word may share a cycle; anything involving a write may not
  for (genvar g = 0; g < N_REQ; g++) begin : g_conf
    assign conflict[g] = (bus.req_addr[g*ADDR_W +: ADDR_W] == a1) && (bus.req_we[g] || we1);
  end
  sram2rw_rr_pick #(.N(N_REQ)) u_pick1 (
    .req(bus.req_valid), .mask('0), .ptr(rr_ptr), .gnt(gnt1), .vld(v1), .idx(idx1)
  );
  sram2rw_rr_pick #(.N(N_REQ)) u_pick2 (
    .req(bus.req_valid), .mask(gnt1 | conflict), .ptr(rr_ptr), .gnt(gnt2), .vld(v2), .idx(idx2)
  );
  assign bus.req_ready = gnt1 | gnt2;
  assign last = v2 ? idx2 : idx1;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      cmd1 <= SRAM_CMD_IDLE;
      cmd2 <= SRAM_CMD_IDLE;
      t1_p1 <= '0;
      t1_p2 <= '0;
      t2_p1 <= '0;
      t2_p2 <= '0;
    end else begin
      if (v1) rr_ptr <= (int'(last) == N_REQ - 1) ? '0 : last + 1'b1;
      cmd1 <= next_cmd(cmd1, v1, we1, a1, bus.req_wdata[idx1*DATA_W +: DATA_W]);
      cmd2 <= next_cmd(cmd2, v2, we2, bus.req_addr[idx2*ADDR_W +: ADDR_W],
                       bus.req_wdata[idx2*DATA_W +: DATA_W]);
      t1_p1 <= '{vld: v1 & ~we1, id: IDW'(idx1)};
      t1_p2 <= '{vld: v2 & ~we2, id: IDW'(idx2)};
      t2_p1 <= t1_p1;
      t2_p2 <= t1_p2;
    end
  end
  assign {sram_csb1, sram_web1, sram_oeb1, sram_a1, sram_i1} = cmd1;
  assign {sram_csb2, sram_web2, sram_oeb2, sram_a2, sram_i2} = cmd2;
  // a requester owns at most one port per cycle, so the two hits are exclusive
  for (genvar g = 0; g < N_REQ; g++) begin : g_resp
    logic h1, h2;
    assign h1 = t2_p1.vld && (t2_p1.id == IDW'(g));
    assign h2 = t2_p2.vld && (t2_p2.id == IDW'(g));
    assign bus.resp_valid[g] = h1 | h2;
    assign bus.resp_rdata[g*DATA_W +: DATA_W] = h1 ? sram_o1 : sram_o2;
  end
endmodule
